// File: rtl/fetch_rf_pkg.sv
// Shared constants and grant encoding for the fetch-stage reference RF arbiter.
// PIXEL_WIDTH sets the line width and defaults to 8-bit pixels.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

package fetch_rf_pkg;

  localparam int FETCH_RF_ADDR_W = 6;
  localparam int FETCH_RF_LINES  = 64;
  localparam int FETCH_RF_DATA_W = 32 * `PIXEL_WIDTH;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/fetch_rf_arb_if.sv
// Requester-side handshake bundle: write loader, read consumer, flush and read return.
interface fetch_rf_arb_if
  import fetch_rf_pkg::*;
#(
  parameter int ADDR_W = FETCH_RF_ADDR_W,
  parameter int DATA_W = FETCH_RF_DATA_W
);
  logic              flush_i;
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              rd_valid_i;
  logic              rd_ready_o;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_dvalid_o;

  modport master (
    output flush_i, wr_valid_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i,
    input  wr_ready_o, rd_ready_o, rd_data_o, rd_dvalid_o
  );

  modport slave (
    input  flush_i, wr_valid_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i,
    output wr_ready_o, rd_ready_o, rd_data_o, rd_dvalid_o
  );
endinterface

// File: rtl/fetch_rf_scoreboard.sv
// Per-line valid vector for the reference RF: set on a granted write, cleared on flush,
// with a combinational lookup for the pending read address.
module fetch_rf_scoreboard #(
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_set_en,
  input  logic [ADDR_W-1:0]        i_set_addr,
  input  logic [ADDR_W-1:0]        i_lookup_addr,
  output logic                     o_hit,
  output logic [(1<<ADDR_W)-1:0]   o_vld
);
  localparam int LINES = 1 << ADDR_W;

  logic [LINES-1:0] r_vld;

  // Flush never coincides with a set because the arbiter grants nothing in a flush cycle.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_vld <= {LINES{1'b0}};
    end else if (i_set_en) begin
      r_vld[i_set_addr] <= 1'b1;
    end
  end

  assign o_hit = r_vld[i_lookup_addr];
  assign o_vld = r_vld;

endmodule

// File: rtl/fetch_rf_arb.sv
// Arbiter for the single-port 64x256 fetch reference RF: write priority, stall on unloaded lines.
// Build macro FETCH_RF_ARB_STARVE_EN adds a bounded write burst ahead of an eligible read.
module fetch_rf_arb
  import fetch_rf_pkg::*;
#(
  parameter int ADDR_W       = FETCH_RF_ADDR_W,
  parameter int DATA_W       = FETCH_RF_DATA_W,
  parameter int WR_BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  fetch_rf_arb_if.slave             req,
  output logic                      wrif_en_o,
  output logic [ADDR_W-1:0]         wrif_addr_o,
  output logic [DATA_W-1:0]         wrif_data_o,
  output logic                      rdif_en_o,
  output logic [ADDR_W-1:0]         rdif_addr_o,
  input  logic [DATA_W-1:0]         rdif_pdata_i,
  output logic [FETCH_RF_LINES-1:0] line_vld_o
);
  gnt_e w_gnt;
  logic w_rd_hit;
  logic w_rd_elig;
  logic w_force_rd;
  logic r_rd_dvalid;

  fetch_rf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (req.flush_i),
    .i_set_en      (w_gnt == GNT_WR),
    .i_set_addr    (req.wr_addr_i),
    .i_lookup_addr (req.rd_addr_i),
    .o_hit         (w_rd_hit),
    .o_vld         (line_vld_o)
  );

  assign w_rd_elig = req.rd_valid_i & w_rd_hit;

`ifdef FETCH_RF_ARB_STARVE_EN
  localparam int CNT_W = $clog2(WR_BURST_MAX + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_force_rd = w_rd_elig && (r_starve_cnt == CNT_W'(WR_BURST_MAX));

  // Counts writes that overtook an eligible read; any break in eligibility restarts it.
  always_ff @(posedge clk) begin
    if (rst || req.flush_i || !w_rd_elig || (w_gnt == GNT_RD)) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (w_gnt == GNT_WR) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_burst;
  assign w_unused_burst = (WR_BURST_MAX > 0);
  assign w_force_rd     = 1'b0;
`endif

  // Grant selection: reset and flush block both sides, then write beats read.
  always_comb begin
    w_gnt = GNT_NONE;
    if (rst || req.flush_i) begin
      w_gnt = GNT_NONE;
    end else if (req.wr_valid_i && !w_force_rd) begin
      w_gnt = GNT_WR;
    end else if (w_rd_elig) begin
      w_gnt = GNT_RD;
    end else begin
      w_gnt = GNT_NONE;
    end
  end

  // RF port drive; the shared address idles on the read address.
  always_comb begin
    wrif_en_o   = 1'b0;
    rdif_en_o   = 1'b0;
    wrif_addr_o = req.rd_addr_i;
    case (w_gnt)
      GNT_WR: begin
        wrif_en_o   = 1'b1;
        wrif_addr_o = req.wr_addr_i;
      end
      GNT_RD: begin
        rdif_en_o = 1'b1;
      end
      default: begin
        wrif_en_o = 1'b0;
        rdif_en_o = 1'b0;
      end
    endcase
  end

  assign rdif_addr_o    = req.rd_addr_i;
  assign wrif_data_o    = req.wr_data_i;
  assign req.wr_ready_o = wrif_en_o;
  assign req.rd_ready_o = rdif_en_o;

  // Data strobe tracks the RF's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_dvalid <= 1'b0;
    end else begin
      r_rd_dvalid <= (w_gnt == GNT_RD);
    end
  end

  // Reset in the return cycle kills the strobe of a read granted just before it.
  assign req.rd_dvalid_o = r_rd_dvalid & ~rst;
  assign req.rd_data_o   = rdif_pdata_i;

endmodule

// File: tb/tb_fetch_rf_arb.sv
// Self-checking bench for fetch_rf_arb: RF model plus read-return scoreboard queue.
module tb_fetch_rf_arb;
  import fetch_rf_pkg::*;

  localparam int DW = FETCH_RF_DATA_W;
  localparam int AW = FETCH_RF_ADDR_W;
`ifdef FETCH_RF_ARB_STARVE_EN
  localparam int EXP_RD_AT = 4;
`else
  localparam int EXP_RD_AT = 16;
`endif

  logic clk;
  logic rst;
  logic          wrif_en;
  logic [AW-1:0] wrif_addr;
  logic [DW-1:0] wrif_data;
  logic          rdif_en;
  logic [AW-1:0] rdif_addr;
  logic [DW-1:0] rdif_pdata;
  logic [FETCH_RF_LINES-1:0] line_vld;

  fetch_rf_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fetch_rf_arb dut (
    .clk          (clk),
    .rst          (rst),
    .req          (bus.slave),
    .wrif_en_o    (wrif_en),
    .wrif_addr_o  (wrif_addr),
    .wrif_data_o  (wrif_data),
    .rdif_en_o    (rdif_en),
    .rdif_addr_o  (rdif_addr),
    .rdif_pdata_i (rdif_pdata),
    .line_vld_o   (line_vld)
  );

  logic [DW-1:0] rf_mem  [FETCH_RF_LINES];
  logic [DW-1:0] ref_mem [FETCH_RF_LINES];
  logic [DW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int cnt, wi, rd_at;
  logic rd_pending;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hD00D_0000 | 32'(i);
    return {(DW/32){w}};
  endfunction

  // Single-port RF stand-in with one-cycle read latency.
  always @(posedge clk) begin
    if (wrif_en) rf_mem[wrif_addr] <= wrif_data;
    if (rdif_en) rdif_pdata <= rf_mem[rdif_addr];
  end

  // Handshake monitor: queue expected read data on grant, compare on the strobe.
  always @(negedge clk) begin
    chk("excl", DW'(bus.wr_ready_o & bus.rd_ready_o), DW'(0));
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.rd_dvalid_o) begin
        if (exp_q.size() == 0) chk("dvalid_unexp", DW'(1), DW'(0));
        else chk("rd_data", bus.rd_data_o, exp_q.pop_front());
      end
      if (bus.rd_ready_o) exp_q.push_back(ref_mem[bus.rd_addr_i]);
      if (bus.wr_ready_o) ref_mem[bus.wr_addr_i] = bus.wr_data_i;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic done;
    done = 1'b0;
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = a;
    bus.wr_data_i  = d;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      done = bus.wr_ready_o;
      step();
    end
    bus.wr_valid_i = 1'b0;
    if (!done) chk("wr_timeout", DW'(0), DW'(1));
  endtask

  initial begin
    rst = 1'b1;
    bus.flush_i    = 1'b0;
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 6'd9;
    bus.wr_data_i  = pat(9);
    bus.rd_valid_i = 1'b0;
    bus.rd_addr_i  = 6'd0;

    // Reset: no grants even with a write requested
    @(negedge clk);
    chk("rst_wr_gnt", DW'(bus.wr_ready_o), DW'(0));
    step();
    bus.wr_valid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_vld", DW'(line_vld), DW'(0));
    chk("rst_dvalid", DW'(bus.rd_dvalid_o), DW'(0));
    step();

    // Read of an unloaded line stalls
    bus.rd_valid_i = 1'b1;
    bus.rd_addr_i  = 6'd5;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rd_ready_o) cnt++;
      step();
    end
    chk("t1_stall", DW'(cnt), DW'(0));
    chk("t1_vld", DW'(line_vld), DW'(0));

    // Write and read of the same line together: write first, read next
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 6'd5;
    bus.wr_data_i  = {(DW/8){8'hA5}};
    @(negedge clk);
    chk("t2_wr_gnt", DW'(bus.wr_ready_o), DW'(1));
    chk("t2_rd_hold", DW'(bus.rd_ready_o), DW'(0));
    step();
    bus.wr_valid_i = 1'b0;
    @(negedge clk);
    chk("t2_rd_gnt", DW'(bus.rd_ready_o), DW'(1));
    chk("t2_dv_early", DW'(bus.rd_dvalid_o), DW'(0));
    step();
    bus.rd_valid_i = 1'b0;
    @(negedge clk);
    chk("t2_dvalid", DW'(bus.rd_dvalid_o), DW'(1));
    chk("t2_data", bus.rd_data_o, {(DW/8){8'hA5}});
    chk("t2_vld", DW'(line_vld), DW'(64'h20));
    step();

    // Write stream to lines 0..15 against an eligible read of line 0
    do_write(6'd0, pat(200));
    wi = 0;
    rd_at = -1;
    rd_pending = 1'b1;
    bus.rd_valid_i = 1'b1;
    bus.rd_addr_i  = 6'd0;
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 6'd0;
    bus.wr_data_i  = pat(0);
    for (int c = 0; c < 40 && (wi < 16 || rd_pending); c++) begin
      @(negedge clk);
      if (bus.rd_ready_o && rd_pending) begin
        rd_pending = 1'b0;
        rd_at = wi;
      end
      if (bus.wr_ready_o) wi++;
      step();
      if (!rd_pending) bus.rd_valid_i = 1'b0;
      if (wi < 16) begin
        bus.wr_addr_i = AW'(wi);
        bus.wr_data_i = pat(wi);
      end else begin
        bus.wr_valid_i = 1'b0;
      end
    end
    bus.wr_valid_i = 1'b0;
    bus.rd_valid_i = 1'b0;
    chk("t3_rd_done", DW'(rd_pending), DW'(0));
    chk("t3_rd_at", DW'(rd_at), DW'(EXP_RD_AT));
    chk("t3_wr_cnt", DW'(wi), DW'(16));
    step();

    // Flush right after writing line 3; read of line 3 must stall until rewritten
    do_write(6'd3, pat(33));
    bus.flush_i    = 1'b1;
    bus.rd_valid_i = 1'b1;
    bus.rd_addr_i  = 6'd3;
    @(negedge clk);
    chk("t4_flush_gnt", DW'(bus.rd_ready_o), DW'(0));
    step();
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("t4_vld", DW'(line_vld), DW'(0));
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.rd_ready_o) cnt++;
      step();
      @(negedge clk);
    end
    chk("t4_stall", DW'(cnt), DW'(0));
    step();
    do_write(6'd3, pat(34));
    @(negedge clk);
    chk("t4_rd_gnt", DW'(bus.rd_ready_o), DW'(1));
    step();
    bus.rd_valid_i = 1'b0;
    @(negedge clk);
    chk("t4_dvalid", DW'(bus.rd_dvalid_o), DW'(1));
    step();

    // Reset in the cycle after a read grant
    bus.rd_valid_i = 1'b1;
    bus.rd_addr_i  = 6'd3;
    @(negedge clk);
    chk("t5_rd_gnt", DW'(bus.rd_ready_o), DW'(1));
    step();
    bus.rd_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_dv_kill", DW'(bus.rd_dvalid_o), DW'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_vld", DW'(line_vld), DW'(0));
    chk("t5_dvalid", DW'(bus.rd_dvalid_o), DW'(0));
    step();

    // Back-to-back reads of lines 0, 1, 2
    for (int i = 0; i < 3; i++) do_write(AW'(i), pat(100 + i));
    bus.rd_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rd_addr_i = AW'(i);
      @(negedge clk);
      chk("t6_rd_gnt", DW'(bus.rd_ready_o), DW'(1));
      if (i > 0) chk("t6_dv_run", DW'(bus.rd_dvalid_o), DW'(1));
      step();
    end
    bus.rd_valid_i = 1'b0;
    @(negedge clk);
    chk("t6_dv_last", DW'(bus.rd_dvalid_o), DW'(1));
    chk("t6_data2", bus.rd_data_o, pat(102));
    step();
    @(negedge clk);
    chk("t6_dv_end", DW'(bus.rd_dvalid_o), DW'(0));
    step();

    chk("q_empty", DW'(exp_q.size()), DW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
